test_ctrl_monitor: RTL and testbench
====================================

Name: test_ctrl_monitor

Overview:
- Synthesizable run-control and end-of-test monitor for the cevero SoC; sits beside the SoC top and drives fetch enable.
- Sequences reset-release → fetch enable, then watches NUM_CH per-core completion flags and result words.
- Compares each result against an expected value and enforces a cycle timeout.
- Reports pass/fail/timeout status for the bench or an on-chip status register.

Parameters:
NUM_CH, 1, number of monitored cores/channels (1..8)
DATA_W, 32, result word width
TIMEOUT_CYCLES, 100, maximum RUN-state cycles before timeout (>=1)
START_DELAY, 2, cycles between start and fetch enable (0 allowed)
CNT_W, $clog2(TIMEOUT_CYCLES+1), cycle counter width (derived, not overridden)

Ports:
clk_i  input  1  clock, rising edge
rst_ni  input  1  asynchronous active-low reset
start_i  input  1  start a run; level-sampled each cycle
flag_i  input  NUM_CH  per-channel completion flag (mem_flag nonzero, reduced by integrator)
result_i  input  NUM_CH*DATA_W  per-channel result; channel c at [c*DATA_W +: DATA_W]
expected_i  input  NUM_CH*DATA_W  per-channel expected result, same packing
fetch_enable_o  output  1  fetch enable to SoC cores
busy_o  output  1  high in DELAY or RUN
done_o  output  1  high in DONE
pass_o  output  1  valid when done_o: all channels done, no mismatch, no timeout
timeout_o  output  1  run ended by timeout
done_mask_o  output  NUM_CH  channels whose flag was captured
fail_mask_o  output  NUM_CH  captured channels whose result != expected
result_o  output  NUM_CH*DATA_W  captured result per channel
cycle_count_o  output  CNT_W  RUN cycles elapsed

Behaviour:
- Reset (async assert, sync-clean deassert): state IDLE; all outputs 0, including result_o, masks, and counter.
- States: IDLE, DELAY, RUN, DONE. All outputs are registered.
- IDLE: start_i=1 → DELAY. If START_DELAY=0, go directly to RUN. Masks, result_o, timeout_o, and counter clear on this edge.
- DELAY:
  - Delay counter counts START_DELAY cycles with fetch_enable_o=0, then RUN.
  - fetch_enable_o rises on the first RUN cycle.
- RUN:
  - fetch_enable_o=1; cycle_count_o increments every RUN cycle.
  - For each channel c with flag_i[c]=1 and done_mask_o[c]=0:
    - result_o[c] ← result_i[c]; done_mask_o[c] ← 1;
    - fail_mask_o[c] ← (result_i[c] != expected_i[c]).
  - Later flag pulses on an already-captured channel are ignored; result is not overwritten.
  - If all channels are done after this cycle's captures → DONE.
  - Else if cycle_count_o == TIMEOUT_CYCLES-1 before increment → DONE with timeout_o ← 1.
  - Final capture and timeout in the same cycle: completion wins; timeout_o=0.
  - Several channels completing in the same cycle are all captured.
- DONE:
  - fetch_enable_o=0; done_o=1; status holds.
  - pass_o = &done_mask_o & ~|fail_mask_o & ~timeout_o.
  - start_i=1 → clear status and enter DELAY (or RUN if START_DELAY=0).
- start_i in DELAY or RUN is ignored.
- cycle_count_o saturates at TIMEOUT_CYCLES; it equals the number of RUN cycles including the terminating one.
- Reset mid-run: immediate return to IDLE; fetch_enable_o drops asynchronously; all status cleared.
- flag_i and result_i are sampled only in RUN; activity in IDLE, DELAY, or DONE has no effect.

Test Plan:
- NUM_CH=1, START_DELAY=2: pulse start_i; flag_i=1 with result_i=55, expected 55, on the 10th RUN cycle.
  → fetch_enable_o rises 3 cycles after the start edge; done_o=1, pass_o=1, cycle_count_o=10, result_o=55.
- NUM_CH=1: flag with result_i=54, expected 55.
  → fail_mask_o=1, pass_o=0, timeout_o=0.
- TIMEOUT_CYCLES=20: flag_i never asserted.
  → after exactly 20 RUN cycles done_o=1, timeout_o=1, pass_o=0, done_mask_o=0, fetch_enable_o=0.
- NUM_CH=2: ch0 flags at RUN cycle 5 (result 8), ch1 at cycle 12 (result 13); flag ch0 again with result 99 at cycle 7.
  → done_o asserts after cycle 12; result_o ch0=8; done_mask_o=2'b11; pass_o=1.
- NUM_CH=2, TIMEOUT_CYCLES=20: ch1 flags on cycle 20, the timeout cycle.
  → completion wins; timeout_o=0, pass_o=1.
- Assert rst_ni=0 at RUN cycle 4, release, then restart from DONE via start_i.
  → all outputs 0 during reset and the second run starts with cleared masks and counter.

Source files
------------

// File: rtl/test_ctrl_monitor.sv
// Run-control and end-of-test monitor: sequences start -> fetch enable,
// captures per-channel completion results, flags mismatches and timeouts.

// Per-channel capture: latch the first flagged result seen while running.
module test_ctrl_monitor_lane #(
  parameter int DATA_W = 32
) (
  input  logic              run,
  input  logic              flag,
  input  logic              captured,
  input  logic [DATA_W-1:0] res_in,
  input  logic [DATA_W-1:0] exp_in,
  input  logic [DATA_W-1:0] res_q,
  input  logic              fail_q,
  output logic              cap,
  output logic [DATA_W-1:0] res_d,
  output logic              fail_d
);
  assign cap    = run & flag & ~captured;
  assign res_d  = cap ? res_in : res_q;
  assign fail_d = cap ? (res_in != exp_in) : fail_q;
endmodule

module test_ctrl_monitor #(
  parameter int NUM_CH         = 1,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 100,
  parameter int START_DELAY    = 2,
  localparam int CNT_W         = $clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     start_i,
  input  logic [NUM_CH-1:0]        flag_i,
  input  logic [NUM_CH*DATA_W-1:0] result_i,
  input  logic [NUM_CH*DATA_W-1:0] expected_i,
  output logic                     fetch_enable_o,
  output logic                     busy_o,
  output logic                     done_o,
  output logic                     pass_o,
  output logic                     timeout_o,
  output logic [NUM_CH-1:0]        done_mask_o,
  output logic [NUM_CH-1:0]        fail_mask_o,
  output logic [NUM_CH*DATA_W-1:0] result_o,
  output logic [CNT_W-1:0]         cycle_count_o
);

  typedef enum logic [1:0] {IDLE, DELAY, RUN, DONE} state_t;

  localparam int DLY_W = (START_DELAY > 1) ? $clog2(START_DELAY) : 1;
  localparam logic [DLY_W-1:0] DLY_LAST  = DLY_W'((START_DELAY > 0) ? START_DELAY - 1 : 0);
  localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);
  // A zero start delay skips the DELAY state entirely.
  localparam state_t START_ST = (START_DELAY == 0) ? RUN : DELAY;

  state_t                          state, state_n;
  logic [DLY_W-1:0]                dcnt, dcnt_n;
  logic [CNT_W-1:0]                cnt, cnt_n;
  logic [NUM_CH-1:0]               dmask, dmask_n, fmask, fmask_n;
  logic [NUM_CH-1:0][DATA_W-1:0]   res_q, res_n;
  logic                            to_q, to_n;
  logic                            fetch_q, busy_q, done_q, pass_q;

  logic [NUM_CH-1:0][DATA_W-1:0]   res_in, exp_in, lane_res;
  logic [NUM_CH-1:0]               lane_cap, lane_fail;
  logic                            running;

  assign res_in  = result_i;
  assign exp_in  = expected_i;
  assign running = (state == RUN);

  for (genvar c = 0; c < NUM_CH; c++) begin : g_lane
    test_ctrl_monitor_lane #(.DATA_W(DATA_W)) u_lane (
      .run      (running),
      .flag     (flag_i[c]),
      .captured (dmask[c]),
      .res_in   (res_in[c]),
      .exp_in   (exp_in[c]),
      .res_q    (res_q[c]),
      .fail_q   (fmask[c]),
      .cap      (lane_cap[c]),
      .res_d    (lane_res[c]),
      .fail_d   (lane_fail[c])
    );
  end

  // Next-state and next-status logic; status only moves in RUN or on a start.
  always_comb begin
    state_n = state;
    dcnt_n  = dcnt;
    cnt_n   = cnt;
    dmask_n = dmask;
    fmask_n = fmask;
    res_n   = res_q;
    to_n    = to_q;
    case (state)
      IDLE, DONE: begin
        if (start_i) begin
          state_n = START_ST;
          dcnt_n  = '0;
          cnt_n   = '0;
          dmask_n = '0;
          fmask_n = '0;
          res_n   = '0;
          to_n    = 1'b0;
        end
      end
      DELAY: begin
        if (dcnt == DLY_LAST) state_n = RUN;
        else                  dcnt_n  = dcnt + DLY_W'(1);
      end
      RUN: begin
        dmask_n = dmask | lane_cap;
        fmask_n = lane_fail;
        res_n   = lane_res;
        cnt_n   = (cnt == CNT_MAX) ? cnt : cnt + CNT_W'(1);
        // Completion is checked first so a last capture on the timeout cycle wins.
        if (&dmask_n) begin
          state_n = DONE;
        end else if (cnt == CNT_LAST) begin
          state_n = DONE;
          to_n    = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // State, status and registered output flags.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state   <= IDLE;
      dcnt    <= '0;
      cnt     <= '0;
      dmask   <= '0;
      fmask   <= '0;
      res_q   <= '0;
      to_q    <= 1'b0;
      fetch_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
    end else begin
      state   <= state_n;
      dcnt    <= dcnt_n;
      cnt     <= cnt_n;
      dmask   <= dmask_n;
      fmask   <= fmask_n;
      res_q   <= res_n;
      to_q    <= to_n;
      fetch_q <= (state_n == RUN);
      busy_q  <= (state_n == DELAY) || (state_n == RUN);
      done_q  <= (state_n == DONE);
      pass_q  <= (state_n == DONE) & (&dmask_n) & ~(|fmask_n) & ~to_n;
    end
  end

  assign fetch_enable_o = fetch_q;
  assign busy_o         = busy_q;
  assign done_o         = done_q;
  assign pass_o         = pass_q;
  assign timeout_o      = to_q;
  assign done_mask_o    = dmask;
  assign fail_mask_o    = fmask;
  assign result_o       = res_q;
  assign cycle_count_o  = cnt;

endmodule

// File: tb/tb_test_ctrl_monitor.sv
// Bench for test_ctrl_monitor: two channels, 20-cycle timeout, start delay 2.
module tb_test_ctrl_monitor;

  localparam int NC = 2;
  localparam int DW = 32;
  localparam int TO = 20;
  localparam int SD = 2;
  localparam int CW = $clog2(TO + 1);

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               start_i = 1'b0;
  logic [NC-1:0]      flag_i = '0;
  logic [NC*DW-1:0]   result_i = '0;
  logic [NC*DW-1:0]   expected_i = '0;
  logic               fetch_enable_o, busy_o, done_o, pass_o, timeout_o;
  logic [NC-1:0]      done_mask_o, fail_mask_o;
  logic [NC*DW-1:0]   result_o;
  logic [CW-1:0]      cycle_count_o;

  int compared = 0;
  int mismatched = 0;

  typedef struct {
    logic [NC-1:0]    dm;
    logic [NC-1:0]    fm;
    logic             to;
    logic             ps;
    logic [CW-1:0]    cnt;
    logic [NC*DW-1:0] res;
  } exp_t;

  exp_t sbq[$];

  test_ctrl_monitor #(.NUM_CH(NC), .DATA_W(DW), .TIMEOUT_CYCLES(TO), .START_DELAY(SD)) dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .start_i        (start_i),
    .flag_i         (flag_i),
    .result_i       (result_i),
    .expected_i     (expected_i),
    .fetch_enable_o (fetch_enable_o),
    .busy_o         (busy_o),
    .done_o         (done_o),
    .pass_o         (pass_o),
    .timeout_o      (timeout_o),
    .done_mask_o    (done_mask_o),
    .fail_mask_o    (fail_mask_o),
    .result_o       (result_o),
    .cycle_count_o  (cycle_count_o)
  );

  always #5 clk = ~clk;

  function automatic exp_t mk(input logic [NC-1:0] dm, input logic [NC-1:0] fm, input logic to,
                              input logic ps, input int cnt, input logic [31:0] r1, input logic [31:0] r0);
    exp_t e;
    e.dm = dm; e.fm = fm; e.to = to; e.ps = ps; e.cnt = CW'(cnt); e.res = {r1, r0};
    return e;
  endfunction

  // Start edge P0: start_i raised after P0, sampled at P1; returns at P1+1.
  task automatic pulse_start();
    @(posedge clk); #1 start_i = 1'b1;
    @(posedge clk); #1 start_i = 1'b0;
  endtask

  // From P1+1, advance through the delay to just inside RUN cycle 1.
  task automatic to_run();
    @(posedge clk); @(posedge clk); #1;
  endtask

  // Drive per-RUN-cycle flags, wait for done_o, then pop and compare the scoreboard.
  task automatic run_flags(input int c0, input logic [31:0] r0, input int c0b, input logic [31:0] r0b,
                           input int c1, input logic [31:0] r1, input int st);
    bit seen = 1'b0;
    exp_t e;
    for (int n = 1; n <= 40 && !seen; n++) begin
      flag_i  = '0;
      start_i = (n == st);
      if (n == c0)  begin flag_i[0] = 1'b1; result_i[31:0]  = r0;  end
      if (n == c0b) begin flag_i[0] = 1'b1; result_i[31:0]  = r0b; end
      if (n == c1)  begin flag_i[1] = 1'b1; result_i[63:32] = r1;  end
      @(posedge clk); #1;
      if (done_o) seen = 1'b1;
    end
    flag_i = '0; start_i = 1'b0;
    compared++;
    if (!seen) begin
      mismatched++;
      $display("FAIL run_done: done_o got 0 want 1 within 40 RUN cycles");
    end else begin
      @(negedge clk);
      compared++;
      if (sbq.size() == 0) begin
        mismatched++;
        $display("FAIL sb_empty: got no expected entry want one");
      end else begin
        e = sbq.pop_front();
        compared += 7;
        if (done_mask_o !== e.dm) begin mismatched++; $display("FAIL sb_done_mask: got %b want %b", done_mask_o, e.dm); end
        if (fail_mask_o !== e.fm) begin mismatched++; $display("FAIL sb_fail_mask: got %b want %b", fail_mask_o, e.fm); end
        if (timeout_o !== e.to) begin mismatched++; $display("FAIL sb_timeout: got %b want %b", timeout_o, e.to); end
        if (pass_o !== e.ps) begin mismatched++; $display("FAIL sb_pass: got %b want %b", pass_o, e.ps); end
        if (cycle_count_o !== e.cnt) begin mismatched++; $display("FAIL sb_cycle_count: got %0d want %0d", cycle_count_o, e.cnt); end
        if (result_o !== e.res) begin mismatched++; $display("FAIL sb_result: got %h want %h", result_o, e.res); end
        if ({fetch_enable_o, busy_o} !== 2'b00) begin mismatched++; $display("FAIL sb_fetch_busy: got %b want 00", {fetch_enable_o, busy_o}); end
      end
    end
  endtask

  task automatic test_reset();
    start_i = 1'b1; flag_i = '1; result_i = '1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    compared += 4;
    if ({fetch_enable_o, busy_o, done_o, pass_o, timeout_o} !== 5'b0) begin
      mismatched++; $display("FAIL reset_flags: got %b want 00000", {fetch_enable_o, busy_o, done_o, pass_o, timeout_o}); end
    if ({done_mask_o, fail_mask_o} !== 4'b0) begin
      mismatched++; $display("FAIL reset_masks: got %b want 0000", {done_mask_o, fail_mask_o}); end
    if (result_o !== 64'h0) begin mismatched++; $display("FAIL reset_result: got %h want 0", result_o); end
    if (cycle_count_o !== '0) begin mismatched++; $display("FAIL reset_count: got %0d want 0", cycle_count_o); end
    start_i = 1'b0; flag_i = '0; result_i = '0;
    rst_n = 1'b1;
  endtask

  task automatic test_pass();
    expected_i = {32'd55, 32'd55};
    sbq.push_back(mk(2'b11, 2'b00, 1'b0, 1'b1, 10, 32'd55, 32'd55));
    pulse_start();
    compared++;
    if ({fetch_enable_o, busy_o} !== 2'b01) begin mismatched++; $display("FAIL delay1_fetch_busy: got %b want 01", {fetch_enable_o, busy_o}); end
    @(posedge clk); #1;
    compared++;
    if (fetch_enable_o !== 1'b0) begin mismatched++; $display("FAIL delay2_fetch: got %b want 0", fetch_enable_o); end
    @(posedge clk); #1;
    compared++;
    if (fetch_enable_o !== 1'b1) begin mismatched++; $display("FAIL run1_fetch: got %b want 1", fetch_enable_o); end
    run_flags(10, 32'd55, 0, 32'd0, 10, 32'd55, 0);
  endtask

  task automatic test_fail();
    expected_i = {32'd55, 32'd55};
    sbq.push_back(mk(2'b11, 2'b01, 1'b0, 1'b0, 3, 32'd55, 32'd54));
    pulse_start();
    flag_i = 2'b11; result_i = '0;   // flags during DELAY must be ignored
    to_run();
    run_flags(3, 32'd54, 0, 32'd0, 3, 32'd55, 0);
  endtask

  task automatic test_timeout();
    sbq.push_back(mk(2'b00, 2'b00, 1'b1, 1'b0, TO, 32'd0, 32'd0));
    pulse_start(); to_run();
    run_flags(0, 32'd0, 0, 32'd0, 0, 32'd0, 0);
  endtask

  task automatic test_two_ch();
    expected_i = {32'd13, 32'd8};
    sbq.push_back(mk(2'b11, 2'b00, 1'b0, 1'b1, 12, 32'd13, 32'd8));
    pulse_start(); to_run();
    run_flags(5, 32'd8, 7, 32'd99, 12, 32'd13, 9);
    // Flag activity while DONE leaves the captured status alone.
    flag_i = 2'b11; result_i = {32'd77, 32'd77};
    repeat (2) @(posedge clk);
    #1 flag_i = '0;
    compared += 2;
    if (result_o !== {32'd13, 32'd8}) begin mismatched++; $display("FAIL done_hold_result: got %h want %h", result_o, {32'd13, 32'd8}); end
    if ({done_o, cycle_count_o} !== {1'b1, CW'(12)}) begin
      mismatched++; $display("FAIL done_hold_count: got %b/%0d want 1/12", done_o, cycle_count_o); end
  endtask

  task automatic test_completion_wins();
    expected_i = {32'd20, 32'd3};
    sbq.push_back(mk(2'b11, 2'b00, 1'b0, 1'b1, TO, 32'd20, 32'd3));
    pulse_start(); to_run();
    run_flags(3, 32'd3, 0, 32'd0, TO, 32'd20, 0);
  endtask

  task automatic test_reset_mid_run();
    expected_i = {32'd5, 32'd5};
    pulse_start(); to_run();
    @(posedge clk); #1;                        // RUN cycle 2
    flag_i = 2'b01; result_i[31:0] = 32'd5;
    @(posedge clk); #1 flag_i = '0;            // RUN cycle 3
    @(posedge clk); #1;                        // RUN cycle 4
    compared++;
    if ({fetch_enable_o, done_mask_o, cycle_count_o} !== {1'b1, 2'b01, CW'(3)}) begin
      mismatched++; $display("FAIL midrun_state: got %b/%b/%0d want 1/01/3", fetch_enable_o, done_mask_o, cycle_count_o); end
    rst_n = 1'b0;
    #1;
    compared += 3;
    if ({fetch_enable_o, busy_o} !== 2'b00) begin mismatched++; $display("FAIL async_fetch_drop: got %b want 00", {fetch_enable_o, busy_o}); end
    if ({done_mask_o, fail_mask_o, timeout_o} !== 5'b0) begin
      mismatched++; $display("FAIL async_status: got %b want 00000", {done_mask_o, fail_mask_o, timeout_o}); end
    if ({result_o, cycle_count_o} !== '0) begin mismatched++; $display("FAIL async_result_count: got %h/%0d want 0/0", result_o, cycle_count_o); end
    @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
  endtask

  task automatic test_restart();
    expected_i = {32'd2, 32'd1};
    sbq.push_back(mk(2'b11, 2'b00, 1'b0, 1'b1, 4, 32'd2, 32'd1));
    pulse_start(); to_run();
    compared++;
    if ({done_mask_o, cycle_count_o, result_o} !== '0) begin
      mismatched++; $display("FAIL restart_idle_clear: got %b/%0d/%h want 0", done_mask_o, cycle_count_o, result_o); end
    run_flags(4, 32'd1, 0, 32'd0, 4, 32'd2, 0);
    // Restart directly from DONE; status must clear on the start edge.
    expected_i = {32'd9, 32'd7};
    sbq.push_back(mk(2'b11, 2'b01, 1'b0, 1'b0, 6, 32'd9, 32'd6));
    pulse_start();
    compared++;
    if ({done_o, pass_o, done_mask_o, cycle_count_o, result_o} !== '0) begin
      mismatched++; $display("FAIL restart_done_clear: got %b%b/%b/%0d/%h want 0", done_o, pass_o, done_mask_o, cycle_count_o, result_o); end
    to_run();
    run_flags(6, 32'd6, 0, 32'd0, 2, 32'd9, 0);
  endtask

  initial begin
    test_reset();
    test_pass();
    test_fail();
    test_timeout();
    test_two_ch();
    test_completion_wins();
    test_reset_mid_run();
    test_restart();
    compared++;
    if (sbq.size() != 0) begin mismatched++; $display("FAIL sb_leftover: got %0d entries want 0", sbq.size()); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
